// File: rtl/data_bram_sched_if.sv
// Bundle of fill stream, request/grant, read-return and BRAM control signals.
// master: the scheduler. slave: loader, gate units and BRAM seen as one peer.
// fill_err exists only when DATA_BRAM_SCHED_DONE_CHECK_EN is defined.
interface data_bram_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_REQ    = 4
);
    logic                          start;
    logic                          in_valid;
    logic [DATA_WIDTH-1:0]         in_data;
    logic                          in_ready;
    logic                          fill_done;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            gnt;
    logic [DATA_WIDTH-1:0]         rd_data;
    logic                          rd_valid;
    logic                          rd_last;
    logic                          bram_we;
    logic                          bram_re;
    logic                          bram_reset_done;
    logic [ADDR_WIDTH-1:0]         bram_wr_addr;
    logic [ADDR_WIDTH-1:0]         bram_rd_addr;
    logic [DATA_WIDTH-1:0]         bram_din;
    logic [DATA_WIDTH-1:0]         bram_dout;
    logic                          bram_done;
`ifdef DATA_BRAM_SCHED_DONE_CHECK_EN
    logic                          fill_err;
`endif

    modport master (
`ifdef DATA_BRAM_SCHED_DONE_CHECK_EN
        output fill_err,
`endif
        input  start, in_valid, in_data, req, req_addr, bram_dout, bram_done,
        output in_ready, fill_done, gnt, rd_data, rd_valid, rd_last,
        output bram_we, bram_re, bram_reset_done, bram_wr_addr, bram_rd_addr, bram_din
    );

    modport slave (
`ifdef DATA_BRAM_SCHED_DONE_CHECK_EN
        input  fill_err,
`endif
        output start, in_valid, in_data, req, req_addr, bram_dout, bram_done,
        input  in_ready, fill_done, gnt, rd_data, rd_valid, rd_last,
        input  bram_we, bram_re, bram_reset_done, bram_wr_addr, bram_rd_addr, bram_din
    );
endinterface

// File: rtl/data_bram_sched.sv
// Fill sequencer + round-robin burst read arbiter for the LSTM global data BRAM.
// Latency: write same cycle as in_valid; read data 1 cycle after bram_re; SERVE->first read 1 cycle.
// Backpressure: in_ready only in FILL; req held by requester until gnt; optional DATA_BRAM_SCHED_DONE_CHECK_EN adds fill_err.
module data_bram_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int MEM_SIZE   = 100,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    data_bram_sched_if.master bus
);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_SERVE = 3'd2,
        S_BURST = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [BEAT_W-1:0]     beats_q, beats_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      gnt_idx_q, gnt_idx_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic                  fill_done_q, fill_done_d;
    logic                  rd_valid_q;
    logic                  rd_last_q;

    logic                  arb_hit;
    logic [IDX_W-1:0]      arb_idx;

    // Round-robin pick: first requesting index at or after rr_ptr, wrapping.
    always_comb begin
        int cand;
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!arb_hit && bus.req[cand[IDX_W-1:0]]) begin
                arb_hit = 1'b1;
                arb_idx = cand[IDX_W-1:0];
            end
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            beats_q     <= '0;
            rr_ptr_q    <= '0;
            gnt_idx_q   <= '0;
            gnt_q       <= '0;
            fill_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            beats_q     <= beats_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_q       <= gnt_d;
            fill_done_q <= fill_done_d;
            rd_valid_q  <= bus.bram_re;
            rd_last_q   <= (state_q == S_BURST) && (beats_q == LAST_BEAT);
        end
    end

    // Next-state logic: fill pointer, arbitration, burst counting and rr update.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        beats_d     = beats_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_d       = gnt_q;
        fill_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FILL;
            end
            S_FILL: begin
                if (bus.in_valid) begin
                    if (wr_ptr_q == LAST_ADDR) begin
                        wr_ptr_d    = '0;
                        fill_done_d = 1'b1;
                        state_d     = S_SERVE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_SERVE: begin
                // A refill request outranks any pending read request.
                if (bus.start) begin
                    wr_ptr_d = '0;
                    state_d  = S_FILL;
                end else if (arb_hit) begin
                    gnt_idx_d = arb_idx;
                    gnt_d     = NUM_REQ'(1) << arb_idx;
                    rd_ptr_d  = bus.req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    beats_d   = '0;
                    state_d   = S_BURST;
                end
            end
            S_BURST: begin
                // Out-of-range start addresses also fall back to 0 on the first step.
                rd_ptr_d = (rd_ptr_q >= LAST_ADDR) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
                beats_d  = beats_q + BEAT_W'(1);
                if (beats_q == LAST_BEAT) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                gnt_d    = '0;
                rr_ptr_d = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + IDX_W'(1);
                state_d  = S_SERVE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: BRAM write/read controls and the fill handshake.
    always_comb begin
        bus.in_ready        = 1'b0;
        bus.bram_we         = 1'b0;
        bus.bram_din        = '0;
        bus.bram_wr_addr    = '0;
        bus.bram_re         = 1'b0;
        bus.bram_rd_addr    = '0;
        bus.bram_reset_done = 1'b0;
        case (state_q)
            S_IDLE:  bus.bram_reset_done = bus.start;
            S_FILL: begin
                bus.in_ready     = 1'b1;
                bus.bram_we      = bus.in_valid;
                bus.bram_wr_addr = wr_ptr_q;
                bus.bram_din     = bus.in_valid ? bus.in_data : '0;
            end
            S_SERVE: bus.bram_reset_done = bus.start;
            S_BURST: begin
                bus.bram_re      = 1'b1;
                bus.bram_rd_addr = rd_ptr_q;
            end
            default: ;
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.fill_done = fill_done_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.rd_data   = bus.bram_dout;

`ifdef DATA_BRAM_SCHED_DONE_CHECK_EN
    logic fill_err_q;
    logic chk_pend_q;
    logic done_prev_q;

    // Flag a BRAM that never reports done after a fill, or drops done while serving.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_err_q  <= 1'b0;
            chk_pend_q  <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            chk_pend_q  <= fill_done_q;
            done_prev_q <= bus.bram_done;
            if (bus.bram_reset_done) begin
                fill_err_q <= 1'b0;
            end else if ((chk_pend_q && !bus.bram_done) ||
                         ((state_q == S_SERVE) && done_prev_q && !bus.bram_done)) begin
                fill_err_q <= 1'b1;
            end
        end
    end

    assign bus.fill_err = fill_err_q;
`else
    logic unused_bram_done;
    assign unused_bram_done = bus.bram_done;
`endif
endmodule

// File: tb/tb_data_bram_sched.sv
module tb_data_bram_sched;
    localparam int DW = 32;
    localparam int AW = 7;
    localparam int MS = 100;
    localparam int NR = 4;
    localparam int BL = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [NR-1:0] gnt;
    } rd_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_bram_sched_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

    data_bram_sched #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS), .NUM_REQ(NR), .BURST_LEN(BL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    int checks = 0;
    int failures = 0;
    int rst_done_pulses = 0;
    int fill_done_pulses = 0;

    // BRAM model with registered read port.
    logic [DW-1:0] mem [0:127];
    always @(posedge clk) begin
        if (bus.bram_we) mem[bus.bram_wr_addr] <= bus.bram_din;
        if (bus.bram_re) bus.bram_dout <= mem[bus.bram_rd_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pop expected read beats and writes as the DUT presents them.
    always @(negedge clk) begin
        rd_exp_t re;
        wr_exp_t we;
        if (bus.rd_valid) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected actual=rd_valid data=%0h required=no_beat", bus.rd_data);
            end else begin
                re = rd_q.pop_front();
                check("rd_data", bus.rd_data, re.data);
                check("rd_last", bus.rd_last, re.last);
                check("rd_gnt", bus.gnt, re.gnt);
            end
        end
        if (bus.bram_we) begin
            if (wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_unexpected actual=addr %0h required=no_write", bus.bram_wr_addr);
            end else begin
                we = wr_q.pop_front();
                check("wr_addr", bus.bram_wr_addr, we.addr);
                check("wr_data", bus.bram_din, we.data);
            end
        end
        if (bus.bram_reset_done) rst_done_pulses++;
        if (bus.fill_done) fill_done_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outputs_zero(input string name);
        @(negedge clk);
        check(name, {bus.in_ready, bus.fill_done, bus.gnt, bus.rd_valid, bus.rd_last,
                     bus.bram_we, bus.bram_re, bus.bram_reset_done,
                     bus.bram_wr_addr, bus.bram_rd_addr, bus.bram_din}, 64'd0);
    endtask

    task automatic start_fill();
        bus.start = 1'b1;
        @(negedge clk);
        check("reset_done_on_start", bus.bram_reset_done, 1'b1);
        tick();
        bus.start = 1'b0;
    endtask

    // Stream MS words base|k; optional in_valid gap before word gap_at.
    task automatic fill_words(input logic [DW-1:0] base, input int gap_at, input int gap_len);
        wr_exp_t e;
        for (int k = 0; k < MS; k++) begin
            if (k == gap_at) begin
                bus.in_valid = 1'b0;
                repeat (gap_len) tick();
            end
            e.addr = AW'(k);
            e.data = base | DW'(k);
            wr_q.push_back(e);
            bus.in_valid = 1'b1;
            bus.in_data  = base | DW'(k);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        @(negedge clk);
        check("fill_done_after_last", bus.fill_done, 1'b1);
        check("in_ready_after_fill", bus.in_ready, 1'b0);
        check("fill_writes_drained", wr_q.size(), 0);
`ifdef DATA_BRAM_SCHED_DONE_CHECK_EN
        @(negedge clk);
        @(negedge clk);
        check("fill_err_set", bus.fill_err, 1'b1);
`endif
        tick();
    endtask

    task automatic push_beats(input int k, input int a, input logic [DW-1:0] base);
        int addr;
        rd_exp_t e;
        addr = a;
        for (int i = 0; i < BL; i++) begin
            e.data = base | DW'(addr);
            e.last = (i == BL - 1);
            e.gnt  = NR'(1) << k;
            rd_q.push_back(e);
            addr = (addr >= MS - 1) ? 0 : addr + 1;
        end
    endtask

    task automatic request(input string name, input logic [NR-1:0] mask, input int exp_k);
        int n;
        n = 0;
        bus.req = mask;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gnt == '0 && n < 20);
        check({name, "_gnt"}, bus.gnt, NR'(1) << exp_k);
        tick();
        bus.req = '0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (rd_q.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_drained"}, rd_q.size(), 0);
        @(negedge clk);
        check({name, "_gnt_release"}, bus.gnt, '0);
        tick();
    endtask

    initial begin
        int rises;
        int gap;
        logic was;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.req       = '0;
        bus.req_addr  = '0;
        bus.bram_done = 1'b0;
        bus.bram_dout = '0;

        repeat (3) tick();
        rst_n = 1'b1;
        outputs_zero("reset_outputs");
        tick();

        // 1: fill 0..99
        start_fill();
        check("in_ready_fill", bus.in_ready, 1'b1);
        fill_words(32'hD000_0000, -1, 0);
        check("reset_done_once", rst_done_pulses, 1);
        check("fill_done_once", fill_done_pulses, 1);

        // 2: requester 0 at 10 -> 10..17
        bus.req_addr[0*AW +: AW] = 7'd10;
        push_beats(0, 10, 32'hD000_0000);
        request("t2", 4'b0001, 0);
        drain("t2");

        // 4: requester 3 at 96 -> 96..99,0..3 (also returns rr pointer to 0)
        bus.req_addr[3*AW +: AW] = 7'd96;
        push_beats(3, 96, 32'hD000_0000);
        request("t4", 4'b1000, 3);
        drain("t4");

        // 3: all requesting -> 0,1,2,3,0 with one idle cycle between bursts
        bus.req_addr = {7'd80, 7'd60, 7'd40, 7'd20};
        push_beats(0, 20, 32'hD000_0000);
        push_beats(1, 40, 32'hD000_0000);
        push_beats(2, 60, 32'hD000_0000);
        push_beats(3, 80, 32'hD000_0000);
        push_beats(0, 20, 32'hD000_0000);
        bus.req = 4'b1111;
        rises = 0;
        gap = 0;
        was = 1'b0;
        for (int c = 0; c < 200 && rises < 5; c++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                if (!was) begin
                    rises++;
                    if (rises > 1) check("t3_burst_gap", gap, 1);
                    gap = 0;
                end
                was = 1'b1;
            end else begin
                gap++;
                was = 1'b0;
            end
        end
        check("t3_grant_count", rises, 5);
        tick();
        bus.req = '0;
        drain("t3");

        // 5a: start beats req in the same SERVE cycle
        bus.start = 1'b1;
        bus.req   = 4'b0001;
        @(negedge clk);
        check("t5_reset_done", bus.bram_reset_done, 1'b1);
        tick();
        bus.start = 1'b0;
        bus.req   = '0;
        @(negedge clk);
        check("t5_no_gnt", bus.gnt, '0);
        check("t5_in_ready", bus.in_ready, 1'b1);
`ifdef DATA_BRAM_SCHED_DONE_CHECK_EN
        check("t5_fill_err_cleared", bus.fill_err, 1'b0);
`endif
        tick();
        fill_words(32'hE000_0000, 50, 3);
        bus.req_addr[1*AW +: AW] = 7'd48;
        push_beats(1, 48, 32'hE000_0000);
        request("t5_refill", 4'b0010, 1);
        drain("t5_refill");

        // 5b: reset in the middle of a burst
        bus.req_addr[2*AW +: AW] = 7'd0;
        push_beats(2, 0, 32'hE000_0000);
        request("t5_rst", 4'b0100, 2);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rd_q.delete();
        rst_n = 1'b1;
        outputs_zero("t5_rst_outputs");
        tick();

        // 5c: after reset rr pointer is back at 0: req 1010 -> requester 1
        start_fill();
        fill_words(32'hF000_0000, -1, 0);
        bus.req_addr[1*AW +: AW] = 7'd5;
        bus.req_addr[3*AW +: AW] = 7'd70;
        push_beats(1, 5, 32'hF000_0000);
        request("t5_rr", 4'b1010, 1);
        drain("t5_rr");

        check("total_reset_done_pulses", rst_done_pulses, 3);
        check("total_fill_done_pulses", fill_done_pulses, 3);
        check("writes_left", wr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_bram_sched.md
Name: data_bram_sched

Overview:
- Sequencer and read-port arbiter for the global data BRAM in the LSTM datapath.
- Fill phase: streams MEM_SIZE input words into the BRAM.
- Serve phase: shares the BRAM read port among NUM_REQ gate units. Each grant is a fixed-length read burst, chosen round-robin.
- Sits between the input loader and the gate compute units. Drives all BRAM control pins.

Parameters:
DATA_WIDTH, 32, word width
ADDR_WIDTH, 7, BRAM address width
MEM_SIZE, 100, words per fill; legal addresses 0..MEM_SIZE-1
NUM_REQ, 4, number of read requesters (i, f, g, o gates)
BURST_LEN, 8, words per granted burst (1..MEM_SIZE)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin a new fill (one-cycle pulse)
in_valid  in  1  input word valid
in_data  in  DATA_WIDTH  input word
in_ready  out  1  high in FILL
fill_done  out  1  one-cycle pulse after the last fill write
req  in  NUM_REQ  per-requester burst request
req_addr  in  NUM_REQ*ADDR_WIDTH  packed burst start addresses; requester k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
gnt  out  NUM_REQ  one-hot grant, held for the whole burst
rd_data  out  DATA_WIDTH  equals bram_dout
rd_valid  out  1  rd_data valid for the granted requester
rd_last  out  1  with the final rd_valid of a burst
bram_we, bram_re, bram_reset_done  out  1 each  BRAM controls
bram_wr_addr, bram_rd_addr  out  ADDR_WIDTH  BRAM addresses
bram_din  out  DATA_WIDTH  BRAM write data
bram_dout  in  DATA_WIDTH  BRAM registered read data
bram_done  in  1  BRAM fill-complete flag

Behaviour:
- Reset (rst_n low at a clock edge, any state):
  - State goes to IDLE.
  - All outputs go to 0, including gnt.
  - Write pointer and read pointer/counter clear.
  - Round-robin pointer set so requester 0 has top priority.
- States: IDLE, FILL, SERVE, BURST, FLUSH.
- IDLE:
  - start -> FILL. bram_reset_done pulses high for that one transition cycle.
- FILL:
  - in_ready=1.
  - Each cycle with in_valid=1: bram_we=1, bram_wr_addr=wr_ptr, bram_din=in_data, then wr_ptr increments.
  - bram_we and bram_din are combinational from in_valid/in_data.
  - The write at wr_ptr==MEM_SIZE-1 ends the fill. Next cycle: state SERVE, fill_done=1 for one cycle, wr_ptr=0.
  - start and req are ignored in FILL.
- SERVE:
  - start=1 -> FILL with a bram_reset_done pulse. start beats req when both are asserted in the same cycle.
  - Otherwise, if any req bit is set: grant the first set bit at or after rr_ptr, wrapping. Latch that requester's address into rd_ptr and set beats=0.
  - gnt is registered and asserted from the first BURST cycle. State -> BURST.
- BURST:
  - bram_re=1 and bram_rd_addr=rd_ptr every cycle.
  - rd_ptr wraps MEM_SIZE-1 -> 0.
  - After BURST_LEN reads -> FLUSH.
- FLUSH:
  - One cycle for the last read's data. gnt stays asserted.
  - Then gnt=0, rr_ptr=granted index+1 (mod NUM_REQ), state -> SERVE.
- Read latency is 1 cycle:
  - rd_valid is bram_re delayed one cycle.
  - rd_last is asserted with the BURST_LEN-th rd_valid.
  - Exactly BURST_LEN rd_valid pulses per grant.
- Request rules:
  - Requester holds req until it sees gnt.
  - Deasserting req mid-burst does not shorten the burst.
  - A latched address >= MEM_SIZE is taken modulo wrap: values above MEM_SIZE-1 wrap to 0 on the first increment, and the first read uses that address as given.
  - Minimum back-to-back spacing: one SERVE cycle between bursts.
- start in BURST or FLUSH is ignored (not queued).

Optional Feature:
- Macro: DATA_BRAM_SCHED_DONE_CHECK_EN.
- When defined:
  - Adds output fill_err (1 bit, reset 0).
  - Two cycles after the last fill write, bram_done is sampled. If it is low, fill_err sets and stays set until reset or the next start.
  - Also, if bram_done is high in SERVE and goes low without a start, fill_err sets.
- When undefined:
  - No fill_err port.
  - bram_done is unused.
  - Behaviour is otherwise identical.

Test Plan:
1. Reset, start, 100 words 0..99 with in_valid held high -> 100 consecutive bram_we; addresses 0..99; fill_done one cycle after the write to 99; bram_reset_done pulsed once.
2. After fill, req=4'b0001, req_addr[0]=10 -> gnt=0001 and reads of addresses 10..17. rd_valid 8 beats returning data 10..17, rd_last on data 17, then gnt=0.
3. req=4'b1111 held continuously -> grants in order 0,1,2,3,0, each exactly 8 beats, with one idle SERVE cycle between bursts.
4. req_addr=96 -> reads 96,97,98,99,0,1,2,3 (wrap); rd_last with data 3.
5. start and req asserted in the same SERVE cycle -> FILL entered, no grant. A gap in in_valid stretches the fill without skipping addresses. rst_n low mid-BURST -> next cycle all outputs 0, state IDLE.
6. With DATA_BRAM_SCHED_DONE_CHECK_EN defined and bram_done tied 0 -> fill_err=1 two cycles after the last write. A following start clears it.
